act_feeder: RTL and testbench

ACT_FEEDER -- requirements
Module: act_feeder

---
 rtl/sblk_pkg.sv | 13 +
 rtl/act_fifo.sv | 61 ++++++
 rtl/act_feeder.sv | 111 +++++++++++
 tb/tb_act_feeder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_pkg.sv
// Shared types and defaults for the activation superblock path.
// Holds the packer state encoding and element/FIFO sizing defaults.
package sblk_pkg;

   localparam int WID_ACT_DEF    = 16;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic {
      HALF_EMPTY = 1'b0,
      HALF_FULL  = 1'b1
   } pack_st_e;

endpackage

// File: rtl/act_fifo.sv
// Packed-word FIFO with a per-entry frame-last tag.
// Head is always presented; pop/push are ignored when empty/full.
module act_fifo
   import sblk_pkg::*;
#(
   parameter int W     = 2 * WID_ACT_DEF,
   parameter int DEPTH = FIFO_DEPTH_DEF
) (
   input  logic         clk_l,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         wlast_i,
   input  logic         pop_i,
   output logic [W-1:0] rdata_o,
   output logic         rlast_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [DEPTH-1:0] last_q;
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_q];
   assign rlast_o = last_q[rd_q];

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         last_q <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
      end else if (clr_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q]  <= wdata_i;
            last_q[wr_q] <= wlast_i;
            wr_q         <= wr_q + AW'(1);
         end
         if (do_pop) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

endmodule

// File: rtl/act_feeder.sv
// Packs activation element pairs into words and queues them for the superblock.
// Also tracks delivered words and pulses on frame completion.
module act_feeder
   import sblk_pkg::*;
#(
   parameter int WID_ACT    = WID_ACT_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int WID_CNT    = 16
) (
   input  logic                 clk_l,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic [WID_ACT-1:0]   s_data,
   input  logic                 s_vld,
   input  logic                 s_last,
   output logic                 s_rdy,
   output logic [2*WID_ACT-1:0] act_data_in,
   output logic                 act_data_in_vld,
   input  logic                 act_data_in_req,
   output logic [WID_CNT-1:0]   word_cnt,
   output logic                 frame_done,
   output logic                 busy
);

   pack_st_e             state_q, state_d;
   logic [WID_ACT-1:0]   half_q, half_d;
   logic [WID_CNT-1:0]   cnt_q;
   logic                 fd_q;
   logic                 push;
   logic [2*WID_ACT-1:0] push_data;
   logic                 push_last;
   logic                 pop;
   logic                 accept;
   logic                 head_last;
   logic                 f_empty;
   logic                 f_full;

   assign s_rdy           = !f_full && !clr;
   assign accept          = s_vld && s_rdy;
   assign act_data_in_vld = !f_empty;
   assign pop             = act_data_in_vld && act_data_in_req && !clr;
   assign word_cnt        = cnt_q;
   assign frame_done      = fd_q;
   assign busy            = (state_q == HALF_FULL) || !f_empty;

   always_comb begin
      state_d   = state_q;
      half_d    = half_q;
      push      = 1'b0;
      push_data = '0;
      push_last = 1'b0;
      if (accept) begin
         unique case (state_q)
            HALF_EMPTY: begin
               if (s_last) begin
                  push      = 1'b1;
                  push_data = {{WID_ACT{1'b0}}, s_data};
                  push_last = 1'b1;
               end else begin
                  half_d  = s_data;
                  state_d = HALF_FULL;
               end
            end
            HALF_FULL: begin
               push      = 1'b1;
               push_data = {s_data, half_q};
               push_last = s_last;
               state_d   = HALF_EMPTY;
            end
            default: state_d = HALF_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_l or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HALF_EMPTY;
         half_q  <= '0;
         cnt_q   <= '0;
         fd_q    <= 1'b0;
      end else if (clr) begin
         state_q <= HALF_EMPTY;
         half_q  <= '0;
         cnt_q   <= '0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         fd_q    <= pop && head_last;
         if (pop) cnt_q <= cnt_q + WID_CNT'(1);
      end
   end

   act_fifo #(
      .W     (2 * WID_ACT),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_l   (clk_l),
      .rst_n   (rst_n),
      .clr_i   (clr),
      .push_i  (push),
      .wdata_i (push_data),
      .wlast_i (push_last),
      .pop_i   (pop),
      .rdata_o (act_data_in),
      .rlast_o (head_last),
      .empty_o (f_empty),
      .full_o  (f_full)
   );

endmodule

// File: tb/tb_act_feeder.sv
// Directed and randomized bench for act_feeder against a queue-based model.
// Every cycle compares handshake, head word, busy, word count and frame pulse.
module tb_act_feeder;
   import sblk_pkg::*;

   localparam int WA = 16;
   localparam int DP = 4;
   localparam int WC = 16;

   logic          clk_l = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic [WA-1:0] s_data = '0;
   logic          s_vld = 1'b0;
   logic          s_last = 1'b0;
   logic          s_rdy;
   logic [2*WA-1:0] act_data_in;
   logic          act_data_in_vld;
   logic          act_data_in_req = 1'b0;
   logic [WC-1:0] word_cnt;
   logic          frame_done;
   logic          busy;

   int checks = 0;
   int errors = 0;

   // model: queue of {last, word}, pending half element, counters
   logic [32:0] mq[$];
   logic        m_hv;
   logic [15:0] m_half;
   int          m_cnt;
   logic        m_fd;
   logic [31:0] got[$];

   act_feeder #(.WID_ACT(WA), .FIFO_DEPTH(DP), .WID_CNT(WC)) dut (
      .clk_l           (clk_l),
      .rst_n           (rst_n),
      .clr             (clr),
      .s_data          (s_data),
      .s_vld           (s_vld),
      .s_last          (s_last),
      .s_rdy           (s_rdy),
      .act_data_in     (act_data_in),
      .act_data_in_vld (act_data_in_vld),
      .act_data_in_req (act_data_in_req),
      .word_cnt        (word_cnt),
      .frame_done      (frame_done),
      .busy            (busy)
   );

   always #5 clk_l = ~clk_l;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      mq.delete();
      m_hv   = 1'b0;
      m_half = '0;
      m_cnt  = 0;
      m_fd   = 1'b0;
   endtask

   task automatic cyc(input logic v, input logic [15:0] d, input logic l,
                      input logic rq, input logic c, output logic acc);
      logic e_rdy, e_vld;
      s_vld = v; s_data = d; s_last = l;
      act_data_in_req = rq; clr = c;
      #1;
      e_rdy = (mq.size() < DP) && !c;
      e_vld = (mq.size() != 0);
      chk("s_rdy", 32'(s_rdy), 32'(e_rdy));
      chk("vld", 32'(act_data_in_vld), 32'(e_vld));
      if (e_vld) chk("data", act_data_in, mq[0][31:0]);
      chk("busy", 32'(busy), 32'(m_hv || e_vld));
      if (e_vld && rq && !c) got.push_back(act_data_in);
      acc = v && e_rdy;
      if (c) begin
         m_reset();
      end else begin
         m_fd = 1'b0;
         if (e_vld && rq) begin
            m_fd = mq[0][32];
            void'(mq.pop_front());
            m_cnt = (m_cnt + 1) % 65536;
         end
         if (acc) begin
            if (m_hv) begin
               mq.push_back({l, d, m_half});
               m_hv = 1'b0;
            end else if (l) begin
               mq.push_back({1'b1, 16'h0, d});
            end else begin
               m_half = d;
               m_hv   = 1'b1;
            end
         end
      end
      @(posedge clk_l); #1;
      chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
      chk("frame_done", 32'(frame_done), 32'(m_fd));
   endtask

   task automatic idle(input logic rq, input int n);
      logic a;
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, rq, 1'b0, a);
   endtask

   task automatic do_clr();
      logic a;
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, a);
   endtask

   initial begin
      logic a;
      int   fd_cnt;
      logic [15:0] e10 [10];
      int   k;
      m_reset();
      repeat (2) @(posedge clk_l);
      #1;
      chk("rst_vld", 32'(act_data_in_vld), 32'h0);
      chk("rst_data", act_data_in, 32'h0);
      chk("rst_cnt", 32'(word_cnt), 32'h0);
      chk("rst_fd", 32'(frame_done), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("rel_rdy", 32'(s_rdy), 32'h1);
      chk("rel_busy", 32'(busy), 32'h0);

      // even frame
      got.delete();
      cyc(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, a);
      cyc(1'b1, 16'h0002, 1'b0, 1'b1, 1'b0, a);
      cyc(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0, a);
      cyc(1'b1, 16'h0004, 1'b1, 1'b1, 1'b0, a);
      idle(1'b1, 3);
      chk("ev_n", got.size(), 2);
      if (got.size() == 2) begin
         chk("ev_w0", got[0], 32'h00020001);
         chk("ev_w1", got[1], 32'h00040003);
      end
      chk("ev_cnt", 32'(word_cnt), 32'd2);

      // odd frame, count frame pulses directly
      do_clr();
      got.delete();
      fd_cnt = 0;
      cyc(1'b1, 16'h00AA, 1'b0, 1'b1, 1'b0, a);
      cyc(1'b1, 16'h00BB, 1'b0, 1'b1, 1'b0, a);
      cyc(1'b1, 16'h00CC, 1'b1, 1'b1, 1'b0, a);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, a);
         if (frame_done) fd_cnt++;
      end
      chk("odd_n", got.size(), 2);
      if (got.size() == 2) begin
         chk("odd_w0", got[0], 32'h00BB00AA);
         chk("odd_w1", got[1], 32'h000000CC);
      end
      chk("odd_fd", fd_cnt, 1);

      // backpressure: 10 elements with req low, then drain
      do_clr();
      got.delete();
      for (int i = 0; i < 10; i++) e10[i] = 16'(16'h0100 + i);
      k = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(k < 10, (k < 10) ? e10[k] : 16'h0, k == 9, 1'b0, 1'b0, a);
         if (a) k++;
      end
      chk("bp_acc", k, 8);
      for (int i = 0; i < 12; i++) begin
         cyc(k < 10, (k < 10) ? e10[k] : 16'h0, k == 9, 1'b1, 1'b0, a);
         if (a) k++;
      end
      chk("bp_n", got.size(), 5);
      for (int i = 0; i < 5 && i < got.size(); i++)
         chk("bp_w", got[i], {e10[2*i+1], e10[2*i]});

      // full FIFO: req and vld in same cycle
      do_clr();
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0, a);
      cyc(1'b1, 16'h0077, 1'b0, 1'b1, 1'b0, a);
      chk("full_noacc", 32'(a), 32'h0);
      cyc(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0, a);
      chk("full_acc", 32'(a), 32'h1);

      // clr with half element and queued words
      do_clr();
      for (int i = 0; i < 5; i++)
         cyc(1'b1, 16'(16'h10 + i), 1'b0, 1'b0, 1'b0, a);
      do_clr();
      chk("clr_vld", 32'(act_data_in_vld), 32'h0);
      chk("clr_busy", 32'(busy), 32'h0);
      chk("clr_cnt", 32'(word_cnt), 32'h0);
      got.delete();
      cyc(1'b1, 16'h0055, 1'b1, 1'b1, 1'b0, a);
      idle(1'b1, 2);
      chk("clr_n", got.size(), 1);
      if (got.size() == 1) chk("clr_w", got[0], 32'h00000055);

      // asynchronous reset mid-frame
      cyc(1'b1, 16'h0A01, 1'b0, 1'b0, 1'b0, a);
      cyc(1'b1, 16'h0A02, 1'b0, 1'b0, 1'b0, a);
      cyc(1'b1, 16'h0A03, 1'b0, 1'b0, 1'b0, a);
      s_vld = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("ar_vld", 32'(act_data_in_vld), 32'h0);
      chk("ar_data", act_data_in, 32'h0);
      chk("ar_busy", 32'(busy), 32'h0);
      chk("ar_cnt", 32'(word_cnt), 32'h0);
      chk("ar_fd", 32'(frame_done), 32'h0);
      m_reset();
      @(posedge clk_l); #1;
      rst_n = 1'b1;
      got.delete();
      cyc(1'b1, 16'h0B01, 1'b0, 1'b1, 1'b0, a);
      cyc(1'b1, 16'h0B02, 1'b1, 1'b1, 1'b0, a);
      idle(1'b1, 2);
      chk("ar_n", got.size(), 1);
      if (got.size() == 1) chk("ar_w", got[0], 32'h0B020B01);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom_range(0, 2) != 0), 16'($urandom),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 49) == 0), a);
      idle(1'b1, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
